// File: rtl/alu_seq.sv
// alu_seq: registered EX-stage ALU with an iterative multiply/divide unit.
// Single-cycle ALU classes (arithmetic, bit-op, shift, compare) register into Z.
// MULT/DIV run one bit per cycle and write HI/LO; busy stalls the pipeline.
//
// Handshake (both sides): a transfer happens on a rising clk edge where the
// producer's valid and the consumer's ready are both high; valid and its data
// never change while valid is high and ready is low.
//
// Optional feature: define ALU_SEQ_OVF_EN to add the registered ovf output
// (signed overflow / unsigned carry-borrow of add and sub).
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       ALUFun,
  input  logic             Sign,
  input  logic [1:0]       md_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Z,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             div0,
`ifdef ALU_SEQ_OVF_EN
  output logic             ovf,
`endif
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Request decode; the reserved md_op code behaves as a plain ALU op.
  logic             accept;
  logic             is_alu, is_mul, is_div;
  logic             b_zero;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic             sgn_a, sgn_b;

  assign accept = in_valid && in_ready;
  assign is_mul = (md_op == 2'b01);
  assign is_div = (md_op == 2'b10);
  assign is_alu = !is_mul && !is_div;
  assign b_zero = (B == '0);
  assign sgn_a  = Sign && A[WIDTH-1];
  assign sgn_b  = Sign && B[WIDTH-1];
  assign abs_a  = sgn_a ? (-A) : A;
  assign abs_b  = sgn_b ? (-B) : B;

  // Iteration state. mcand is the multiplicand (MUL) or divisor (DIV);
  // acc_hi/acc_lo are the partial product, or remainder/shifting dividend.
  logic [WIDTH-1:0] mcand, acc_hi, acc_lo;
  logic [SHW:0]     cnt;
  logic             neg_q, neg_r, dz, is_div_op;

  // ---------------- single-cycle ALU ----------------
  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] alu_z;
  logic             cmp_flag;
  logic             a_neg, a_zero, lt_flag;

  assign sh     = A[SHW-1:0];
  assign a_neg  = A[WIDTH-1];
  assign a_zero = (A == '0);
  assign lt_flag = Sign ? ($signed(A) < $signed(B)) : (A < B);

  // Compare flag; the zero tests look at A as a signed value and ignore B.
  always_comb begin
    cmp_flag = 1'b0;
    case (ALUFun[3:1])
      3'b001:  cmp_flag = (A == B);
      3'b000:  cmp_flag = (A != B);
      3'b010:  cmp_flag = lt_flag;
      3'b110:  cmp_flag = a_neg || a_zero;
      3'b101:  cmp_flag = a_neg;
      3'b111:  cmp_flag = !a_neg && !a_zero;
      default: cmp_flag = 1'b0;
    endcase
  end

  // ALU result selected by operation class.
  always_comb begin
    alu_z = '0;
    case (ALUFun[5:4])
      2'b00: alu_z = ALUFun[0] ? (A - B) : (A + B);
      2'b01: begin
        case (ALUFun[3:0])
          4'b1000: alu_z = A & B;
          4'b1110: alu_z = A | B;
          4'b0110: alu_z = A ^ B;
          4'b0001: alu_z = ~(A | B);
          4'b1010: alu_z = A;
          default: alu_z = '0;
        endcase
      end
      2'b10: begin
        case (ALUFun[1:0])
          2'b00:   alu_z = B << sh;
          2'b01:   alu_z = B >> sh;
          2'b11:   alu_z = $unsigned($signed(B) >>> sh);
          default: alu_z = '0;
        endcase
      end
      default: alu_z = {{(WIDTH-1){1'b0}}, cmp_flag};
    endcase
  end

`ifdef ALU_SEQ_OVF_EN
  logic [WIDTH:0] add_ext, sub_ext;
  logic           ovf_calc;
  logic [WIDTH-1:0] arith_r;

  assign add_ext = {1'b0, A} + {1'b0, B};
  assign sub_ext = {1'b0, A} - {1'b0, B};
  assign arith_r = ALUFun[0] ? sub_ext[WIDTH-1:0] : add_ext[WIDTH-1:0];

  // Signed: operand signs allow overflow and the result sign disagrees with A.
  // Unsigned: carry-out of the add, or borrow (top bit) of the subtract.
  always_comb begin
    ovf_calc = 1'b0;
    if (Sign) begin
      if (ALUFun[0])
        ovf_calc = (A[WIDTH-1] != B[WIDTH-1]) && (arith_r[WIDTH-1] != A[WIDTH-1]);
      else
        ovf_calc = (A[WIDTH-1] == B[WIDTH-1]) && (arith_r[WIDTH-1] != A[WIDTH-1]);
    end else begin
      ovf_calc = ALUFun[0] ? sub_ext[WIDTH] : add_ext[WIDTH];
    end
  end

  // ovf follows each accepted op: arithmetic ops set it, anything else clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      ovf <= 1'b0;
    else if (accept)
      ovf <= is_alu && (ALUFun[5:4] == 2'b00) && ovf_calc;
  end
`endif

  // ---------------- iterative mul/div step ----------------
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_rem2, div_diff;
  logic             div_ok;
  logic [WIDTH-1:0] step_hi, step_lo;

  assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
  assign div_rem2 = {acc_hi, acc_lo[WIDTH-1]};
  assign div_diff = div_rem2 - {1'b0, mcand};
  assign div_ok   = !div_diff[WIDTH];

  // One shift-add (MUL) or restoring-subtract (DIV) step on the live registers.
  always_comb begin
    if (is_div_op) begin
      step_hi = div_ok ? div_diff[WIDTH-1:0] : div_rem2[WIDTH-1:0];
      step_lo = {acc_lo[WIDTH-2:0], div_ok};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  // Final values: DONE applies the last step and then the sign fix-up.
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   fin_hi, fin_lo;

  assign prod     = {step_hi, step_lo};
  assign prod_fix = neg_q ? (-prod) : prod;

  // Select the result written to HI/LO when DONE retires.
  always_comb begin
    fin_hi = '0;
    fin_lo = '0;
    if (dz) begin
      fin_hi = acc_lo;
      fin_lo = '1;
    end else if (is_div_op) begin
      fin_hi = neg_r ? (-step_hi) : step_hi;
      fin_lo = neg_q ? (-step_lo) : step_lo;
    end else begin
      fin_hi = prod_fix[2*WIDTH-1:WIDTH];
      fin_lo = prod_fix[WIDTH-1:0];
    end
  end

  // ---------------- FSM ----------------
  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  // Next state. cnt counts steps still owed; the last step is folded into
  // DONE, so the result lands WIDTH+1 edges after acceptance.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept && is_mul)
          state_nxt = S_MUL;
        else if (accept && is_div)
          state_nxt = b_zero ? S_DONE : S_DIV;
      end
      S_MUL, S_DIV: begin
        if (cnt == (SHW+1)'(2))
          state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    in_ready  = (state == S_IDLE) && (!out_valid || out_ready);
    dbg_state = state;
  end

  // Operand latch at acceptance and per-cycle iteration.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand     <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      cnt       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      dz        <= 1'b0;
      is_div_op <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept && is_mul) begin
            mcand     <= abs_a;
            acc_lo    <= abs_b;
            acc_hi    <= '0;
            neg_q     <= sgn_a ^ sgn_b;
            neg_r     <= 1'b0;
            dz        <= 1'b0;
            is_div_op <= 1'b0;
            cnt       <= (SHW+1)'(WIDTH);
          end else if (accept && is_div) begin
            mcand     <= abs_b;
            acc_lo    <= b_zero ? A : abs_a;
            acc_hi    <= '0;
            neg_q     <= sgn_a ^ sgn_b;
            neg_r     <= sgn_a;
            dz        <= b_zero;
            is_div_op <= 1'b1;
            cnt       <= (SHW+1)'(WIDTH);
          end
        end
        S_MUL, S_DIV: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt - (SHW+1)'(1);
        end
        default: ;
      endcase
    end
  end

  // Architectural results and the output handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Z         <= '0;
      hi        <= '0;
      lo        <= '0;
      div0      <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (accept && is_alu)
        Z <= alu_z;

      if (accept && !is_alu)
        busy <= 1'b1;
      else if (state == S_DONE)
        busy <= 1'b0;

      if (state == S_DONE) begin
        hi <= fin_hi;
        lo <= fin_lo;
        if (is_div_op)
          div0 <= dz;
      end

      if ((accept && is_alu) || (state == S_DONE))
        out_valid <= 1'b1;
      else if (out_ready)
        out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: randomized + directed bench for alu_seq (WIDTH = 32) with a
// queue-based scoreboard fed by an arithmetic reference model.
module tb_alu_seq;
  localparam int W = 32;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [5:0]   ALUFun = '0;
  logic         Sign = 1'b0;
  logic [1:0]   md_op = '0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] Z, hi, lo;
  logic         busy, div0;
  logic [1:0]   dbg_state;
`ifdef ALU_SEQ_OVF_EN
  logic         ovf;
`endif

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ALUFun(ALUFun), .Sign(Sign), .md_op(md_op), .A(A), .B(B),
    .out_valid(out_valid), .out_ready(out_ready), .Z(Z), .hi(hi), .lo(lo),
    .busy(busy), .div0(div0),
`ifdef ALU_SEQ_OVF_EN
    .ovf(ovf),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic [W-1:0] z;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div0;
    logic         ovf;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         mon_e;
  int           checks = 0;
  int           failures = 0;
  int           ready_mode = 1;  // 0: hold low, 1: hold high, 2: random

  // Reference architectural state.
  logic [W-1:0] m_z = '0, m_hi = '0, m_lo = '0;
  logic         m_div0 = 1'b0, m_ovf = 1'b0;

  localparam logic [5:0] FUN_TAB [16] = '{
    6'b000000, 6'b000001, 6'b011000, 6'b011110, 6'b010110, 6'b010001,
    6'b011010, 6'b100000, 6'b100001, 6'b100011, 6'b110010, 6'b110000,
    6'b110100, 6'b111100, 6'b111010, 6'b111110
  };

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the request.
  task automatic model_apply(input logic [5:0] fun, input logic sg, input logic [1:0] md,
                             input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, s, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (md == 2'b01) begin
      if (sg) p = 64'(sa * sb);
      else    p = 64'(a) * 64'(b);
      m_hi = p[63:32];
      m_lo = p[31:0];
      m_ovf = 1'b0;
    end else if (md == 2'b10) begin
      if (b == '0) begin
        m_lo = '1; m_hi = a; m_div0 = 1'b1;
      end else begin
        if (sg) begin
          q = sa / sb; r = sa % sb;
          m_lo = q[31:0]; m_hi = r[31:0];
        end else begin
          m_lo = a / b; m_hi = a % b;
        end
        m_div0 = 1'b0;
      end
      m_ovf = 1'b0;
    end else begin
      m_ovf = 1'b0;
      case (fun[5:4])
        2'b00: begin
          if (fun[0]) begin
            m_z = a - b;
            s = sa - sb;
            m_ovf = sg ? (s > SMAX || s < SMIN) : (a < b);
          end else begin
            m_z = a + b;
            s = sa + sb;
            m_ovf = sg ? (s > SMAX || s < SMIN) : ((64'(a) + 64'(b)) > 64'hFFFF_FFFF);
          end
        end
        2'b01: begin
          case (fun[3:0])
            4'b1000: m_z = a & b;
            4'b1110: m_z = a | b;
            4'b0110: m_z = a ^ b;
            4'b0001: m_z = ~(a | b);
            4'b1010: m_z = a;
            default: m_z = '0;
          endcase
        end
        2'b10: begin
          case (fun[1:0])
            2'b00:   m_z = b << a[4:0];
            2'b01:   m_z = b >> a[4:0];
            2'b11:   m_z = 32'(sb >>> a[4:0]);
            default: m_z = '0;
          endcase
        end
        default: begin
          case (fun[3:1])
            3'b001:  m_z = 32'(a == b);
            3'b000:  m_z = 32'(a != b);
            3'b010:  m_z = sg ? 32'(sa < sb) : 32'(a < b);
            3'b110:  m_z = 32'(sa <= 0);
            3'b101:  m_z = 32'(sa < 0);
            3'b111:  m_z = 32'(sa > 0);
            default: m_z = '0;
          endcase
        end
      endcase
    end
    exp_q.push_back('{z: m_z, hi: m_hi, lo: m_lo, div0: m_div0, ovf: m_ovf});
  endtask

  // ---------------- driver ----------------
  // Holds the request until accepted; returns 1 time unit after the accepting edge.
  task automatic issue(input logic [5:0] fun, input logic sg, input logic [1:0] md,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    bit done = 1'b0;
    ALUFun = fun; Sign = sg; md_op = md; A = a; B = b;
    in_valid = 1'b1;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        model_apply(fun, sg, md, a, b);
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
    if (!done) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  // Counts edges from acceptance (edge 1) to out_valid, busy cycles, and
  // cycles where in_ready was high while busy.
  task automatic wait_out(input string name, input int exp_lat, input int exp_busy);
    int n = 1, nb = 0, nir = 0;
    while (!out_valid && n < 200) begin
      if (busy) nb++;
      if (busy && in_ready) nir++;
      @(posedge clk);
      #1;
      n++;
    end
    chk({name, "_latency"}, 64'(n), 64'(exp_lat));
    chk({name, "_busy_cycles"}, 64'(nb), 64'(exp_busy));
    chk({name, "_ready_while_busy"}, 64'(nir), 64'd0);
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      if (exp_q.size() == 0 && !out_valid) ok = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    if (!ok) chk("drain_timeout", 64'd0, 64'd1);
  endtask

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 32'd1;
      2:       return '1;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- consumer backpressure ----------------
  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_z", 64'(Z), 64'(mon_e.z));
        chk("sb_hi", 64'(hi), 64'(mon_e.hi));
        chk("sb_lo", 64'(lo), 64'(mon_e.lo));
        chk("sb_div0", 64'(div0), 64'(mon_e.div0));
`ifdef ALU_SEQ_OVF_EN
        chk("sb_ovf", 64'(ovf), 64'(mon_e.ovf));
`endif
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- main sequence ----------------
  logic [5:0]   r_fun;
  logic [1:0]   r_md;
  logic         r_sg;
  logic [W-1:0] r_a, r_b;

  initial begin
    #3 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_z", 64'(Z), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_div0", 64'(div0), 64'd0);
`ifdef ALU_SEQ_OVF_EN
    chk("rst_ovf", 64'(ovf), 64'd0);
`endif
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // SUB 5-7, signed and unsigned
    issue(6'b000001, 1'b1, 2'b00, 32'd5, 32'd7);
    wait_out("sub_s", 1, 0);
    chk("sub_s_z", 64'(Z), 64'hFFFF_FFFE);
`ifdef ALU_SEQ_OVF_EN
    chk("sub_s_ovf", 64'(ovf), 64'd0);
`endif
    issue(6'b000001, 1'b0, 2'b00, 32'd5, 32'd7);
    wait_out("sub_u", 1, 0);
`ifdef ALU_SEQ_OVF_EN
    chk("sub_u_ovf", 64'(ovf), 64'd1);
`endif

    // SRA and LT
    issue(6'b100011, 1'b0, 2'b00, 32'd4, 32'h8000_0000);
    wait_out("sra", 1, 0);
    chk("sra_z", 64'(Z), 64'hF800_0000);
    issue(6'b110101, 1'b1, 2'b00, 32'hFFFF_FFFF, 32'd1);
    wait_out("lt_s", 1, 0);
    chk("lt_s_z", 64'(Z), 64'd1);
    issue(6'b110101, 1'b0, 2'b00, 32'hFFFF_FFFF, 32'd1);
    wait_out("lt_u", 1, 0);
    chk("lt_u_z", 64'(Z), 64'd0);

    // Signed MULT
    issue(6'b000000, 1'b1, 2'b01, 32'hFFFF_FFFD, 32'h7FFF_FFFF);
    wait_out("mult", 33, 32);
    chk("mult_hi", 64'(hi), 64'hFFFF_FFFE);
    chk("mult_lo", 64'(lo), 64'h8000_0003);
    chk("mult_z_kept", 64'(Z), 64'd0);

    // Signed DIV, divide by zero, and the wrap case
    issue(6'b000000, 1'b1, 2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_out("div", 33, 32);
    chk("div_lo", 64'(lo), 64'hFFFF_FFFD);
    chk("div_hi", 64'(hi), 64'hFFFF_FFFF);
    issue(6'b000000, 1'b0, 2'b10, 32'd9, 32'd0);
    wait_out("div_zero", 2, 1);
    chk("div_zero_lo", 64'(lo), 64'hFFFF_FFFF);
    chk("div_zero_hi", 64'(hi), 64'd9);
    chk("div_zero_flag", 64'(div0), 64'd1);
    issue(6'b000000, 1'b1, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_out("div_wrap", 33, 32);
    chk("div_wrap_lo", 64'(lo), 64'h8000_0000);
    chk("div_wrap_hi", 64'(hi), 64'd0);
    chk("div_wrap_flag", 64'(div0), 64'd0);
    drain();

    // Backpressure: result held, second request stalled until out_ready
    ready_mode = 0;
    @(posedge clk);
    #1;
    issue(6'b000000, 1'b0, 2'b00, 32'd1000, 32'd234);
    fork
      issue(6'b000000, 1'b0, 2'b00, 32'd7, 32'd8);
      begin
        repeat (4) begin
          @(negedge clk);
          chk("bp_out_valid", 64'(out_valid), 64'd1);
          chk("bp_z_held", 64'(Z), 64'd1234);
          chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        ready_mode = 1;
      end
    join
    drain();

    // Reset in the middle of a MULT
    issue(6'b000000, 1'b0, 2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
    wait_out("mult_u", 33, 32);
    drain();
    issue(6'b000000, 1'b0, 2'b01, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    exp_q.delete();
    m_z = '0; m_hi = '0; m_lo = '0; m_div0 = 1'b0; m_ovf = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_late_hi", 64'(hi), 64'd0);
    chk("abort_no_late_valid", 64'(out_valid), 64'd0);

    // Randomized traffic under random backpressure
    ready_mode = 2;
    for (int k = 0; k < 150; k++) begin
      r_md  = 2'($urandom_range(0, 3));
      r_sg  = 1'($urandom_range(0, 1));
      r_fun = ($urandom_range(0, 1) == 0) ? FUN_TAB[$urandom_range(0, 15)] : 6'($urandom);
      r_a   = rnd_operand();
      r_b   = rnd_operand();
      issue(r_fun, r_sg, r_md, r_a, r_b);
    end
    ready_mode = 1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
